spi_master: RTL and testbench

//  Master end of the team's 3-byte SPI register protocol (CPOL=0, MSB first): {slave ID, address, data}.

---
 rtl/spi_master.sv | 122 ++++++++++++
 tb/tb_spi_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: 3-byte {ID, address, data} SPI register master, CPOL=0, MSB first
module spi_master #(
   parameter int unsigned CLK_DIV   = 8,
   parameter int unsigned SS_GAP    = 8,
   parameter logic [7:0]  SLAVE_IDW = 8'hFF,
   parameter logic [7:0]  SLAVE_IDR = 8'h00
) (
   input  logic       clock,
   input  logic       n_reset,
   input  logic       start,
   input  logic       rw,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       ss,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso
);
   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
   localparam logic [7:0] DIV_END = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_END = 8'(SS_GAP - 1);
   state_t      state, state_d;
   logic [23:0] tx, tx_d, frame;
   logic [4:0]  bit_cnt, bit_cnt_d;
   logic [7:0]  div, div_d, rx, rx_d, rdata_d;
   logic        rw_q, rw_d, busy_d, done_d, ss_d, sclk_d, mosi_d;
   assign frame = {rw ? SLAVE_IDW : SLAVE_IDR, addr, rw ? wdata : 8'h00};
   // next-state and next-output logic; every output is registered below
   always_comb begin
      state_d   = state;
      tx_d      = tx;
      bit_cnt_d = bit_cnt;
      div_d     = div + 8'd1;
      rx_d      = rx;
      rdata_d   = rdata;
      rw_d      = rw_q;
      busy_d    = busy;
      done_d    = 1'b0;
      ss_d      = ss;
      sclk_d    = sclk;
      mosi_d    = mosi;
      case (state)
         IDLE: begin
            div_d = 8'd0;
            if (start) begin
               state_d   = LEAD;
               tx_d      = frame;
               rw_d      = rw;
               bit_cnt_d = 5'd0;
               ss_d      = 1'b0;
               mosi_d    = frame[23];
               busy_d    = 1'b1;
            end
         end
         LEAD: if (div == DIV_END) begin
            div_d   = 8'd0;
            sclk_d  = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: if (div == DIV_END) begin
            div_d  = 8'd0;
            sclk_d = ~sclk;
            if (sclk) begin
               if (!rw_q && bit_cnt >= 5'd16) rx_d = {rx[6:0], miso};
               if (bit_cnt == 5'd23) state_d = TRAIL;
               else begin
                  bit_cnt_d = bit_cnt + 5'd1;
                  tx_d      = {tx[22:0], 1'b0};
                  mosi_d    = tx[22];
               end
            end
         end
         TRAIL: if (div == DIV_END) begin
            div_d   = 8'd0;
            ss_d    = 1'b1;
            mosi_d  = 1'b0;
            state_d = GAP;
         end
         GAP: if (div == GAP_END) begin
            div_d   = 8'd0;
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            rdata_d = rw_q ? rdata : rx;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and output registers; reset aborts any frame without a done pulse
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state   <= IDLE;
         tx      <= 24'h0;
         bit_cnt <= 5'd0;
         div     <= 8'd0;
         rx      <= 8'h00;
         rdata   <= 8'h00;
         rw_q    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ss      <= 1'b1;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
      end else begin
         state   <= state_d;
         tx      <= tx_d;
         bit_cnt <= bit_cnt_d;
         div     <= div_d;
         rx      <= rx_d;
         rdata   <= rdata_d;
         rw_q    <= rw_d;
         busy    <= busy_d;
         done    <= done_d;
         ss      <= ss_d;
         sclk    <= sclk_d;
         mosi    <= mosi_d;
      end
   end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: cycle model plus register-target model checking spi_master
module tb_spi_master;
   localparam int CD = 4;
   localparam int SG = 8;
   localparam int DONE_T = 49*CD + SG + 1;
   logic       clock = 1'b0;
   logic       n_reset;
   logic       start, rw, miso;
   logic [7:0] addr, wdata, rdata;
   logic       busy, done, ss, sclk, mosi;
   int checks = 0;
   int failures = 0;

   spi_master #(.CLK_DIV(CD), .SS_GAP(SG), .SLAVE_IDW(8'hFF), .SLAVE_IDR(8'h00)) dut (
      .clock(clock), .n_reset(n_reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .rdata(rdata), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso)
   );

   always #5 clock = ~clock;

   // expected {ss,sclk,mosi,busy,done} at cycle t of a frame (t=1 is the cycle after accept)
   function automatic logic [4:0] exp_pins(input int t, input logic [23:0] f);
      int u, b;
      u = t - (CD + 1);
      b = (u < CD) ? 0 : (u - CD) / (2*CD) + 1;
      if (b > 23) b = 23;
      return {!(t >= 1 && t <= 49*CD), (u >= 0 && u < 47*CD && (u / CD) % 2 == 0),
              (t <= 49*CD) && f[23-b], (t >= 1 && t <= 49*CD + SG), t == DONE_T};
   endfunction

   // frame-level model: which frame is in flight, its offset, and the expected rdata
   logic        m_act;
   int          m_t;
   logic [23:0] m_tx;
   logic        m_rw;
   logic [7:0]  m_rd;
   logic [7:0]  m_reg [4] = '{default: 8'h00};
   always @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         m_act <= 1'b0;
         m_t   <= 0;
         m_rd  <= 8'h00;
      end else begin
         if ((!m_act || m_t == DONE_T) && start) begin
            m_act <= 1'b1;
            m_t   <= 1;
            m_tx  <= {rw ? 8'hFF : 8'h00, addr, rw ? wdata : 8'h00};
            m_rw  <= rw;
         end else if (m_act && m_t == DONE_T) m_act <= 1'b0;
         else if (m_act) m_t <= m_t + 1;
         if (m_act && m_t == DONE_T - 1) begin
            if (m_rw && m_tx[15:10] == 6'b000100) m_reg[m_tx[9:8]] <= m_tx[7:0];
            else if (!m_rw) m_rd <= (m_tx[15:10] == 6'b000100) ? m_reg[m_tx[9:8]] : 8'h00;
         end
      end
   end

   // register target: 4 registers at 0x10..0x13, others read as zero
   logic        s_sclk_p = 1'b0;
   int          s_cnt = 0;
   logic [23:0] s_sh = 24'h0;
   logic [23:0] s_last = 24'h0;
   logic [7:0]  s_id = 8'h00;
   logic [7:0]  s_addr = 8'h00;
   logic [7:0]  s_reg [4] = '{default: 8'h00};
   always @(posedge clock) begin
      s_sclk_p <= sclk;
      if (ss) begin
         s_cnt <= 0;
         miso  <= 1'b0;
      end else if (sclk && !s_sclk_p) begin
         s_sh  <= {s_sh[22:0], mosi};
         s_cnt <= s_cnt + 1;
         if (s_cnt == 15) begin
            s_id   <= s_sh[14:7];
            s_addr <= {s_sh[6:0], mosi};
         end
         if (s_cnt >= 16 && s_id == 8'h00)
            miso <= (s_addr[7:2] == 6'b000100) ? s_reg[s_addr[1:0]][23-s_cnt] : 1'b0;
         if (s_cnt == 23) begin
            s_last <= {s_sh[22:0], mosi};
            if (s_id == 8'hFF && s_addr[7:2] == 6'b000100) s_reg[s_addr[1:0]] <= {s_sh[6:0], mosi};
         end
      end
   end

   // waveform measurements: edge spacing, ss setup/hold, ss gap, mosi stability
   int   cyc = 0, rises = 0, dones = 0, mosi_bad = 0;
   int   t_fall = 0, t_rise = 0, first_edge = 0, last_edge = 0, n_edges = 0, bad_phase = 0;
   int   gap = 0, setup = 0, hold = 0, fr_edges = 0, phase_bad = 0;
   logic sclk_p = 1'b0, ss_p = 1'b1, mosi_p = 1'b0;
   always @(negedge clock) begin
      cyc      <= cyc + 1;
      sclk_p   <= sclk;
      ss_p     <= ss;
      mosi_p   <= mosi;
      rises    <= rises + int'(sclk && !sclk_p);
      dones    <= dones + int'(done);
      mosi_bad <= mosi_bad + int'(sclk && sclk_p && mosi != mosi_p);
      if (!ss && ss_p) begin
         t_fall    <= cyc;
         n_edges   <= 0;
         bad_phase <= 0;
         gap       <= cyc - t_rise;
      end else if (!ss && sclk != sclk_p) begin
         if (n_edges == 0) first_edge <= cyc;
         else if (cyc - last_edge != CD) bad_phase <= bad_phase + 1;
         last_edge <= cyc;
         n_edges   <= n_edges + 1;
      end
      if (ss && !ss_p) begin
         t_rise    <= cyc;
         setup     <= first_edge - t_fall;
         hold      <= cyc - last_edge;
         fr_edges  <= n_edges;
         phase_bad <= bad_phase;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic wait_done(input string name);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
         step();
         got = done;
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_done required=done", name);
      end
   endtask

   task automatic run_frame(input logic r, input logic [7:0] a, input logic [7:0] d, output int len);
      int c0;
      rw = r;
      addr = a;
      wdata = d;
      start = 1'b1;
      c0 = cyc;
      @(posedge clock);
      #1;
      start = 1'b0;
      rw = ~r;
      addr = 8'($urandom);
      wdata = 8'($urandom);
      wait_done("frame");
      len = cyc - c0 + 1;
   endtask

   initial begin
      int len, r0, d0, nd;
      start = 1'b0;
      rw = 1'b0;
      addr = 8'h00;
      wdata = 8'h00;
      n_reset = 1'b1;
      #1 n_reset = 1'b0;
      fork
         forever begin
            @(negedge clock);
            checks++;
            if ({ss, sclk, mosi, busy, done, rdata} !== {(m_act ? exp_pins(m_t, m_tx) : 5'b10000), m_rd}) begin
               failures++;
               $display("FAIL pins t=%0d actual=%b_%h required=%b_%h", m_act ? m_t : 0,
                        {ss, sclk, mosi, busy, done}, rdata, m_act ? exp_pins(m_t, m_tx) : 5'b10000, m_rd);
            end
         end
      join_none
      repeat (3) step();
      chk("reset_pins", {27'd0, ss, sclk, mosi, busy, done}, 32'b10000);
      chk("reset_rdata", {24'd0, rdata}, 32'h00);
      n_reset = 1'b1;
      step();
      r0 = rises;
      run_frame(1'b1, 8'h11, 8'hA5, len);
      chk("t1_len", len, 32'd206);
      chk("t1_mosi", s_last, 32'hFF11A5);
      chk("t1_rises", rises - r0, 32'd24);
      chk("t1_reg11", {24'd0, s_reg[1]}, 32'hA5);
      run_frame(1'b0, 8'h11, 8'h00, len);
      chk("t2_mosi", s_last, 32'h001100);
      chk("t2_rdata", {24'd0, rdata}, 32'hA5);
      run_frame(1'b1, 8'h12, 8'h77, len);
      chk("t2_hold", {24'd0, rdata}, 32'hA5);
      run_frame(1'b1, 8'h10, 8'h3C, len);
      run_frame(1'b1, 8'h13, 8'hC3, len);
      run_frame(1'b0, 8'h10, 8'h00, len);
      chk("t3_rd10", {24'd0, rdata}, 32'h3C);
      run_frame(1'b0, 8'h13, 8'h00, len);
      chk("t3_rd13", {24'd0, rdata}, 32'hC3);
      run_frame(1'b0, 8'h20, 8'h00, len);
      chk("t3_rd20", {24'd0, rdata}, 32'h00);
      rw = 1'b1;
      addr = 8'h10;
      wdata = 8'h55;
      start = 1'b1;
      nd = 0;
      for (int i = 1; i <= 260; i++) begin
         step();
         start = (i == 5 || i == 100);
         addr = 8'h12;
         wdata = 8'hEE;
         if (done) nd++;
      end
      start = 1'b0;
      chk("t4_one_done", nd, 32'd1);
      chk("t4_reg10", {24'd0, s_reg[0]}, 32'h55);
      chk("t4_reg12", {24'd0, s_reg[2]}, 32'h77);
      d0 = dones;
      rw = 1'b0;
      addr = 8'h10;
      start = 1'b1;
      wait_done("t4_held1");
      repeat (20) step();
      start = 1'b0;
      wait_done("t4_held2");
      chk("t4_dones", dones - d0, 32'd2);
      chk("t4_gap", gap, 32'd9);
      chk("t4_rdata", {24'd0, rdata}, 32'h55);
      d0 = dones;
      rw = 1'b1;
      addr = 8'h12;
      wdata = 8'hEE;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (59) step();
      n_reset = 1'b0;
      step();
      chk("t5_pins", {27'd0, ss, sclk, mosi, busy, done}, 32'b10000);
      chk("t5_rdata", {24'd0, rdata}, 32'h00);
      repeat (2) step();
      n_reset = 1'b1;
      repeat (250) step();
      chk("t5_no_done", dones - d0, 32'd0);
      chk("t5_reg12_kept", {24'd0, s_reg[2]}, 32'h77);
      run_frame(1'b1, 8'h12, 8'h5A, len);
      chk("t5_reg12", {24'd0, s_reg[2]}, 32'h5A);
      run_frame(1'b0, 8'h12, 8'h00, len);
      chk("t5_rdata12", {24'd0, rdata}, 32'h5A);
      run_frame(1'b1, 8'h13, 8'h81, len);
      chk("t6_len", len, 32'd206);
      chk("t6_setup", setup, CD);
      chk("t6_hold", hold, CD);
      chk("t6_edges", fr_edges, 32'd48);
      chk("t6_phase", phase_bad, 32'd0);
      chk("t6_mosi_stable", mosi_bad, 32'd0);
      chk("t6_mosi", s_last, 32'hFF1381);
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
